// File: rtl/obi_data_responder.sv
// Memory-side responder for a req/gnt/rvalid data port: word RAM, fixed response
// latency, bounded outstanding FIFO and optional LFSR-driven grant stalls.
module obi_data_responder #(
  parameter int          ADDR_WIDTH      = 12,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          RESP_LATENCY    = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               data_req_i,
  input  logic [31:0]                        data_addr_i,
  input  logic                               data_we_i,
  input  logic [3:0]                         data_be_i,
  input  logic [31:0]                        data_wdata_i,
  output logic                               data_gnt_o,
  output logic                               data_rvalid_o,
  output logic [31:0]                        data_rdata_o,
  output logic                               data_err_o,
  input  logic                               stall_en_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int LW    = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam logic [LW-1:0] LOAD = LW'(RESP_LATENCY - 1);

  logic [31:0]           mem     [DEPTH];
  logic [31:0]           q_rdata [MAX_OUTSTANDING];
  logic                  q_err   [MAX_OUTSTANDING];
  logic [LW-1:0]         q_cnt   [MAX_OUTSTANDING];

  logic [15:0]           lfsr;
  logic                  stall;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  accept;
  logic                  pop;
  logic                  in_range;
  logic [ADDR_WIDTH-3:0] widx;
  logic [31:0]           resp_rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) ptr_inc = '0;
    else                               ptr_inc = p + 1'b1;
  endfunction

  assign stall      = stall_en_i & lfsr[0];
  assign data_gnt_o = data_req_i & ~stall & (count < CW'(MAX_OUTSTANDING));
  assign accept     = data_req_i & data_gnt_o;
  assign in_range   = (data_addr_i[31:ADDR_WIDTH] == '0);
  assign widx       = data_addr_i[ADDR_WIDTH-1:2];

  always_comb begin
    resp_rdata = 32'h0;
    if (!data_we_i) resp_rdata = in_range ? mem[widx] : 32'hDEADBEEF;
  end

  // The head leaves one cycle before its rvalid so the registered response lands
  // RESP_LATENCY cycles after the grant (RESP_LATENCY=1 behaves like 2).
  assign pop = (count != '0) && (q_cnt[rd_ptr] <= LW'(1));

  always_ff @(posedge clk_i) begin
    if (accept && data_we_i && in_range) begin
      for (int k = 0; k < 4; k++)
        if (data_be_i[k]) mem[widx][8*k +: 8] <= data_wdata_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      q_cnt[i] <= (q_cnt[i] != '0) ? q_cnt[i] - 1'b1 : '0;
    if (accept && !rst_i) begin
      q_rdata[wr_ptr] <= resp_rdata;
      q_err[wr_ptr]   <= ~in_range;
      q_cnt[wr_ptr]   <= LOAD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr          <= LFSR_SEED;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= 32'h0;
      data_err_o    <= 1'b0;
    end else begin
      // taps 16,14,13,11
      lfsr          <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      data_rvalid_o <= pop;
      data_rdata_o  <= pop ? q_rdata[rd_ptr] : 32'h0;
      data_err_o    <= pop & q_err[rd_ptr];
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
    end
  end

  assign outstanding_o = count;

endmodule

// File: tb/tb_obi_data_responder.sv
// Directed and randomized bench for obi_data_responder; two instances (latency 2
// and 6) checked every cycle against a transaction-level reference model.
module tb_obi_data_responder;

  localparam int          AW   = 12;
  localparam int          MO   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        stall_en;
  logic        gnt [2];
  logic        rv  [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic [2:0]  outs [2];

  always #5 clk = ~clk;

  obi_data_responder #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .RESP_LATENCY(2), .LFSR_SEED(SEED)) u_dut_l2 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[0]), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[0]), .data_rvalid_o(rv[0]),
    .data_rdata_o(rdata[0]), .data_err_o(err[0]), .stall_en_i(stall_en), .outstanding_o(outs[0]));

  obi_data_responder #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .RESP_LATENCY(6), .LFSR_SEED(SEED)) u_dut_l6 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req[1]), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_gnt_o(gnt[1]), .data_rvalid_o(rv[1]),
    .data_rdata_o(rdata[1]), .data_err_o(err[1]), .stall_en_i(stall_en), .outstanding_o(outs[1]));

  // reference model state
  logic [15:0] lfsr_m;
  logic [31:0] mem_m  [2][1024];
  bit          mem_ok [2][1024];
  int          q_due  [2][64];
  logic [31:0] q_rd   [2][64];
  logic        q_er   [2][64];
  bit          q_ok   [2][64];
  int          q_hd [2], q_tl [2];
  bit          last_g [2];
  int          gnt_cnt [2], rv_cnt [2];
  int          cyc, checks, errors, peak;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 6;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      bit   exp_rv, exp_g, inr;
      int   cnt, slot, ix;
      exp_rv = (q_hd[d] != q_tl[d]) && (q_due[d][q_hd[d] % 64] == cyc);
      cnt    = q_tl[d] - q_hd[d] - (exp_rv ? 1 : 0);
      exp_g  = req[d] && !(stall_en && lfsr_m[0]) && (cnt < MO);
      chk($sformatf("gnt[%0d]", d), {31'b0, gnt[d]}, {31'b0, exp_g});
      chk($sformatf("rvalid[%0d]", d), {31'b0, rv[d]}, {31'b0, exp_rv});
      chk($sformatf("outstanding[%0d]", d), {29'b0, outs[d]}, 32'(cnt));
      if (d == 1 && int'(outs[1]) > peak) peak = int'(outs[1]);
      if (exp_rv) begin
        slot = q_hd[d] % 64;
        if (q_ok[d][slot]) chk($sformatf("rdata[%0d]", d), rdata[d], q_rd[d][slot]);
        chk($sformatf("err[%0d]", d), {31'b0, err[d]}, {31'b0, q_er[d][slot]});
        rv_cnt[d]++;
        q_hd[d]++;
      end else begin
        chk($sformatf("rdata_idle[%0d]", d), rdata[d], 32'h0);
        chk($sformatf("err_idle[%0d]", d), {31'b0, err[d]}, 32'h0);
      end
      last_g[d] = exp_g;
      if (exp_g) begin
        inr  = (addr < 32'(1 << AW));
        ix   = int'(addr[AW-1:2]);
        slot = q_tl[d] % 64;
        if (we) begin
          if (inr) begin
            for (int k = 0; k < 4; k++)
              if (be[k]) mem_m[d][ix][8*k +: 8] = wdata[8*k +: 8];
            if (be == 4'hF) mem_ok[d][ix] = 1'b1;
          end
          q_rd[d][slot] = 32'h0;
          q_ok[d][slot] = 1'b1;
        end else begin
          q_rd[d][slot] = inr ? mem_m[d][ix] : 32'hDEADBEEF;
          q_ok[d][slot] = inr ? mem_ok[d][ix] : 1'b1;
        end
        q_er[d][slot]  = !inr;
        q_due[d][slot] = cyc + lat(d);
        q_tl[d]++;
        gnt_cnt[d]++;
      end
    end
    if (rst) begin
      lfsr_m = SEED;
      for (int d = 0; d < 2; d++) q_hd[d] = q_tl[d];
    end else begin
      lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b, output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    addr = a; we = w; wdata = wd; be = b; req[d] = 1'b1;
    while (!done) begin
      tick();
      waited++;
      done = last_g[d];
      if (!done && waited > 200) begin
        chk("gnt_timeout", 32'h0, 32'h1);
        done = 1'b1;
      end
    end
    req[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_hd[0] != q_tl[0] || q_hd[1] != q_tl[1]) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_done", {31'b0, (q_hd[0] == q_tl[0] && q_hd[1] == q_tl[1])}, 32'h1);
  endtask

  initial begin
    int w;
    checks = 0; errors = 0; peak = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      q_hd[d] = 0; q_tl[d] = 0; gnt_cnt[d] = 0; rv_cnt[d] = 0; req[d] = 1'b0;
      for (int i = 0; i < 1024; i++) mem_ok[d][i] = 1'b0;
    end
    addr = '0; we = 1'b0; be = '0; wdata = '0; stall_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lfsr_m = SEED;
    rst = 1'b0;
    tick();

    // latency and write-then-read
    xfer(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, w);
    chk("lat_wr_gnt_immediate", 32'(w), 32'd1);
    xfer(0, 1'b0, 32'h100, 32'h0, 4'hF, w);
    chk("lat_rd_gnt_immediate", 32'(w), 32'd1);
    tick();
    chk("lat_rvalid_at_2", {31'b0, rv[0]}, 32'h1);
    chk("lat_rdata", rdata[0], 32'hCAFEF00D);
    drain();

    // byte enables
    xfer(0, 1'b1, 32'h40, 32'h11223344, 4'hF, w);
    xfer(0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, w);
    xfer(0, 1'b0, 32'h42, 32'h0, 4'hF, w);
    drain();
    chk("byte_enable_model", mem_m[0][16], 32'h11BB33DD);

    // out of range: read, then a dropped write aliasing word 0
    xfer(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, w);
    xfer(0, 1'b0, 32'h2000, 32'h0, 4'hF, w);
    xfer(0, 1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF, w);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, w);
    drain();

    // back-pressure on the latency-6 instance
    for (int k = 0; k < 8; k++) xfer(1, 1'b1, 32'(k * 4), 32'h1000 + 32'(k), 4'hF, w);
    drain();
    peak = 0;
    for (int k = 0; k < 8; k++) xfer(1, 1'b0, 32'(k * 4), 32'h0, 4'hF, w);
    drain();
    chk("backpressure_peak", 32'(peak), 32'd4);

    // random stalls
    stall_en = 1'b1;
    gnt_cnt[0] = 0; rv_cnt[0] = 0;
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h2000 + 32'($urandom_range(0, 15) << 2);
      else                           a = 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      xfer(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), w);
    end
    drain();
    chk("rvalid_count_eq_gnt_count", 32'(rv_cnt[0]), 32'(gnt_cnt[0]));
    stall_en = 1'b0;

    // reset with three reads in flight
    xfer(1, 1'b1, 32'h80, 32'h0BADF00D, 4'hF, w);
    drain();
    for (int k = 0; k < 3; k++) xfer(1, 1'b0, 32'h80, 32'h0, 4'hF, w);
    chk("pre_reset_outstanding", {29'b0, outs[1]}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_reset_outstanding", {29'b0, outs[1]}, 32'd0);
    for (int k = 0; k < 8; k++) tick();
    xfer(1, 1'b0, 32'h80, 32'h0, 4'hF, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
